// File: rtl/key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_event_decoder                                            |
// | Description : Three independent per-key gesture decoders turning debounced|
// |               active-low key levels into click / double-click / long-press |
// |               one-cycle pulses, plus a per-key busy flag.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_event_decoder #(
  parameter logic [23:0] LONG_CNT = 24'd12_000_000,
  parameter logic [23:0] DBL_GAP  = 24'd3_600_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_lvl_n,
  output logic [2:0] click,
  output logic [2:0] dbl_click,
  output logic [2:0] long_press,
  output logic [2:0] busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_t;

  // Terminal counter values: the transition fires on the cycle the counter
  // reaches N-1, so the event lands exactly N cycles after entering the state.
  localparam logic [23:0] C_LONG_LAST = LONG_CNT - 24'd1;
  localparam logic [23:0] C_DBL_LAST  = DBL_GAP - 24'd1;

  // Cleared by reset and set by the first clock afterwards. While clear, the
  // FSMs stand still so that the first clock only loads the key history;
  // a key held through reset therefore never looks like a fresh press.
  logic armed_q;
  logic armed_d;

  assign armed_d = 1'b1;

  // Arm the decoders one clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_key
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        key_prev_q, key_prev_d;   // previous key level (key_d)
    logic        click_q, click_d;
    logic        dbl_q, dbl_d;
    logic        long_q, long_d;
    logic        press_edge;
    logic        release_edge;

    // Next-state, counter and event-pulse computation for this key
    always_comb begin
      press_edge   = key_prev_q & ~key_lvl_n[i];
      release_edge = ~key_prev_q & key_lvl_n[i];
      key_prev_d   = key_lvl_n[i];
      state_d      = state_q;
      cnt_d        = cnt_q;
      click_d      = 1'b0;
      dbl_d        = 1'b0;
      long_d       = 1'b0;
      if (armed_q) begin
        unique case (state_q)
          ST_IDLE: begin
            cnt_d = 24'd0;
            if (press_edge) begin
              state_d = ST_PRESS1;
            end
          end
          ST_PRESS1: begin
            // A release on the terminal cycle still counts as a short press.
            if (release_edge) begin
              state_d = ST_WAIT2;
              cnt_d   = 24'd0;
            end else if (cnt_q == C_LONG_LAST) begin
              state_d = ST_LONG_HELD;
              cnt_d   = 24'd0;
              long_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          ST_WAIT2: begin
            // A re-press on the terminal cycle still counts as a double click.
            if (press_edge) begin
              state_d = ST_PRESS2;
              cnt_d   = 24'd0;
            end else if (cnt_q == C_DBL_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = 24'd0;
              click_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          ST_PRESS2: begin
            cnt_d = 24'd0;
            if (release_edge) begin
              state_d = ST_IDLE;
              dbl_d   = 1'b1;
            end
          end
          ST_LONG_HELD: begin
            cnt_d = 24'd0;
            if (release_edge) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = 24'd0;
          end
        endcase
      end
    end

    // State, counter, key history and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        cnt_q      <= 24'd0;
        key_prev_q <= 1'b1;
        click_q    <= 1'b0;
        dbl_q      <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        key_prev_q <= key_prev_d;
        click_q    <= click_d;
        dbl_q      <= dbl_d;
        long_q     <= long_d;
      end
    end

    assign click[i]      = click_q;
    assign dbl_click[i]  = dbl_q;
    assign long_press[i] = long_q;
    assign busy[i]       = (state_q != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_event_decoder                                         |
// | Description : Self-checking bench for key_event_decoder; directed gesture  |
// |               scenarios followed by random key activity, all checked       |
// |               against a timestamp-based gesture model.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_key_event_decoder;

  localparam int LC = 20;
  localparam int DG = 10;

  // Gesture phases of the reference model
  localparam int P_NONE  = 0;
  localparam int P_DOWN1 = 1;
  localparam int P_GAP   = 2;
  localparam int P_DOWN2 = 3;
  localparam int P_LONG  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_lvl_n = 3'b111;
  logic [2:0] click;
  logic [2:0] dbl_click;
  logic [2:0] long_press;
  logic [2:0] busy;

  key_event_decoder #(
    .LONG_CNT(24'd20),
    .DBL_GAP (24'd10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_lvl_n (key_lvl_n),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each gesture is tracked by the clock index at which its
  // current press or release was seen; events fire when the elapsed time hits
  // LC (still held) or DG (still released).
  int         ph[3];
  int         t_mark[3];
  logic       prev[3];
  bit         armed;
  int         now;
  logic [2:0] e_click, e_dbl, e_long;
  int         seen_click[3], seen_dbl[3], seen_long[3];

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i]     = P_NONE;
      t_mark[i] = 0;
      prev[i]   = 1'b1;
    end
    armed   = 1'b0;
    e_click = 3'b000;
    e_dbl   = 3'b000;
    e_long  = 3'b000;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 3; i++) begin
      seen_click[i] = 0;
      seen_dbl[i]   = 0;
      seen_long[i]  = 0;
    end
  endtask

  // Advance the model by one clock using the key levels present at the edge
  task automatic model_edge();
    logic k;
    bit   pe, re;
    e_click = 3'b000;
    e_dbl   = 3'b000;
    e_long  = 3'b000;
    if (!armed) begin
      for (int i = 0; i < 3; i++) prev[i] = key_lvl_n[i];
      armed = 1'b1;
    end else begin
      now++;
      for (int i = 0; i < 3; i++) begin
        k  = key_lvl_n[i];
        pe = prev[i] && !k;
        re = !prev[i] && k;
        case (ph[i])
          P_NONE: if (pe) begin ph[i] = P_DOWN1; t_mark[i] = now; end
          P_DOWN1: begin
            if (re) begin
              ph[i] = P_GAP; t_mark[i] = now;
            end else if (now - t_mark[i] == LC) begin
              ph[i] = P_LONG; e_long[i] = 1'b1;
            end
          end
          P_GAP: begin
            if (pe) begin
              ph[i] = P_DOWN2;
            end else if (now - t_mark[i] == DG) begin
              ph[i] = P_NONE; e_click[i] = 1'b1;
            end
          end
          P_DOWN2: if (re) begin ph[i] = P_NONE; e_dbl[i] = 1'b1; end
          default: if (re) ph[i] = P_NONE;
        endcase
        prev[i] = k;
      end
    end
  endtask

  task automatic step(input logic [2:0] k);
    logic [2:0] e_busy;
    key_lvl_n = k;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    for (int i = 0; i < 3; i++) e_busy[i] = (ph[i] != P_NONE);
    chk("click", click, e_click);
    chk("dbl_click", dbl_click, e_dbl);
    chk("long_press", long_press, e_long);
    chk("busy", busy, e_busy);
    for (int i = 0; i < 3; i++) begin
      seen_click[i] += int'(click[i]);
      seen_dbl[i]   += int'(dbl_click[i]);
      seen_long[i]  += int'(long_press[i]);
    end
  endtask

  task automatic run(input logic [2:0] k, input int n);
    for (int j = 0; j < n; j++) step(k);
  endtask

  int         rem[3];
  logic [2:0] lvl;

  initial begin
    now = 0;
    model_reset();
    clear_seen();

    // Reset state
    #2;
    chk("rst_click", click, 3'b000);
    chk("rst_dbl", dbl_click, 3'b000);
    chk("rst_long", long_press, 3'b000);
    chk("rst_busy", busy, 3'b000);
    #10 rst_n = 1'b1;
    run(3'b111, 3);

    // Single short press on key0
    clear_seen();
    run(3'b110, 5);
    run(3'b111, DG + 5);
    chk_cnt("k0_click_cnt", seen_click[0], 1);
    chk_cnt("k0_dbl_cnt", seen_dbl[0], 0);
    chk_cnt("k0_long_cnt", seen_long[0], 0);

    // Double click on key1
    clear_seen();
    run(3'b101, 5);
    run(3'b111, 4);
    run(3'b101, 5);
    run(3'b111, DG + 3);
    chk_cnt("k1_dbl_cnt", seen_dbl[1], 1);
    chk_cnt("k1_click_cnt", seen_click[1], 0);

    // Long press on key2
    clear_seen();
    run(3'b011, 40);
    run(3'b111, 5);
    chk_cnt("k2_long_cnt", seen_long[2], 1);
    chk_cnt("k2_click_cnt", seen_click[2], 0);

    // Re-press exactly on the last gap cycle: double click, no click
    clear_seen();
    run(3'b110, 5);
    run(3'b111, DG);
    run(3'b110, 3);
    run(3'b111, DG + 3);
    chk_cnt("gap_edge_dbl", seen_dbl[0], 1);
    chk_cnt("gap_edge_click", seen_click[0], 0);

    // Release exactly on the last hold cycle: short press, no long press
    clear_seen();
    run(3'b110, LC);
    run(3'b111, DG + 3);
    chk_cnt("hold_edge_long", seen_long[0], 0);
    chk_cnt("hold_edge_click", seen_click[0], 1);

    // One cycle longer: long press
    clear_seen();
    run(3'b110, LC + 1);
    run(3'b111, DG + 3);
    chk_cnt("hold_over_long", seen_long[0], 1);
    chk_cnt("hold_over_click", seen_click[0], 0);

    // All keys short-pressed together
    clear_seen();
    run(3'b000, 5);
    run(3'b111, DG + 3);
    chk_cnt("all_click", seen_click[0] + seen_click[1] + seen_click[2], 3);

    // Reset during key0 PRESS1 with the key held through reset
    clear_seen();
    run(3'b110, 5);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", busy, 3'b000);
    chk("mid_rst_click", click, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(3'b110, 30);
    chk_cnt("held_after_rst", seen_click[0] + seen_dbl[0] + seen_long[0], 0);
    run(3'b111, 3);
    run(3'b110, 3);
    run(3'b111, DG + 3);
    chk_cnt("repress_after_rst", seen_click[0], 1);

    // Random activity, durations spanning both timing boundaries
    lvl = 3'b111;
    for (int i = 0; i < 3; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = ~lvl[i];
          rem[i] = int'($urandom_range(1, 26));
        end
        rem[i]--;
      end
      step(lvl);
    end
    run(3'b111, LC + DG + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
